// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable clock divider producing a tick strobe and a divided level
// Optional phase restart input sync_i is compiled in when CLKDIV_SYNC_EN is defined.
`timescale 1ns/1ps
module clk_div_prog #(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 4
) (
    input  logic             clkin_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_ld_i,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_i,
`endif
    output logic             clkout_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] div_cur_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] DIV_MIN_V = CNT_W'(2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pend_q, pend_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] div_clamped;
    logic             wrap;
    logic             sync_req;
    logic [CNT_W:0]   half_thresh;

    assign div_clamped = (div_i < DIV_MIN_V) ? DIV_MIN_V : div_i;
    assign wrap        = en_i && (cnt_q == (div_cur_q - 1'b1));

`ifdef CLKDIV_SYNC_EN
    assign sync_req = sync_i;
`else
    assign sync_req = 1'b0;
`endif

    // Threshold is ceil(D/2); the extra bit keeps D = 2**CNT_W-1 from overflowing.
    assign half_thresh = ({1'b0, div_cur_d} + 1'b1) >> 1;

    always_comb begin
        cnt_d     = cnt_q;
        div_cur_d = div_cur_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        tick_d    = 1'b0;
        clkout_d  = clkout_q;

        if (sync_req) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (div_ld_i) begin
                div_cur_d = div_clamped;
            end else if (pend_q) begin
                div_cur_d = pending_q;
            end
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            pend_d = 1'b0;
            if (div_ld_i) begin
                div_cur_d = div_clamped;
            end else if (pend_q) begin
                div_cur_d = pending_q;
            end
        end else begin
            if (en_i) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (div_ld_i) begin
                pending_d = div_clamped;
                pend_d    = 1'b1;
            end
        end

        if (sync_req) begin
            clkout_d = 1'b0;
        end else if (en_i) begin
            clkout_d = ({1'b0, cnt_d} >= half_thresh);
        end
    end

    always_ff @(posedge clkin_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            div_cur_q <= DIV_RST_V;
            pending_q <= DIV_RST_V;
            pend_q    <= 1'b0;
            clkout_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_cur_q <= div_cur_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
        end
    end

    assign clkout_o  = clkout_q;
    assign tick_o    = tick_q;
    assign cnt_o     = cnt_q;
    assign div_cur_o = div_cur_q;
    assign pend_o    = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - randomized self-checking bench for clk_div_prog against a cycle reference model
`timescale 1ns/1ps
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] div = '0;
    logic        div_ld = 1'b0;
    logic        sync = 1'b0;
    logic        clkout, tick, pend;
    logic [15:0] cnt, div_cur;

    int total = 0;
    int bad = 0;

    int m_cnt, m_d, m_pending;
    bit m_pend, m_tick, m_clk;

`ifdef CLKDIV_SYNC_EN
    localparam bit HAS_SYNC = 1'b1;
`else
    localparam bit HAS_SYNC = 1'b0;
`endif

    always #5 clk = ~clk;

    clk_div_prog #(.CNT_W(16), .DIV_RESET(4)) dut (
        .clkin_i   (clk),
        .rst_i     (rst),
        .en_i      (en),
        .div_i     (div),
        .div_ld_i  (div_ld),
`ifdef CLKDIV_SYNC_EN
        .sync_i    (sync),
`endif
        .clkout_o  (clkout),
        .tick_o    (tick),
        .cnt_o     (cnt),
        .div_cur_o (div_cur),
        .pend_o    (pend)
    );

    function automatic int clamp(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Advance one clock; the model follows the divider rules with integer arithmetic.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_clk = 0; m_tick = 0; m_d = 4; m_pend = 0; m_pending = 4;
        end else if (HAS_SYNC && sync) begin
            m_cnt = 0; m_clk = 0; m_tick = 0;
            if (div_ld) m_d = clamp(int'(div));
            else if (m_pend) m_d = m_pending;
            m_pend = 0;
        end else if (en) begin
            if (m_cnt == m_d - 1) begin
                m_cnt = 0; m_tick = 1;
                if (div_ld) m_d = clamp(int'(div));
                else if (m_pend) m_d = m_pending;
                m_pend = 0;
            end else begin
                m_cnt = (m_cnt + 1) % 65536; m_tick = 0;
                if (div_ld) begin m_pending = clamp(int'(div)); m_pend = 1; end
            end
            m_clk = (m_cnt >= (m_d + 1) / 2);
        end else begin
            m_tick = 0;
            if (div_ld) begin m_pending = clamp(int'(div)); m_pend = 1; end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; div_ld = 0; sync = 0;
        step(); step();
        total++;
        if ({clkout, tick, cnt, div_cur, pend} !== {1'b0, 1'b0, 16'd0, 16'd4, 1'b0}) begin
            bad++;
            $display("FAIL reset: got clk=%0b tick=%0b cnt=%0d div=%0d pend=%0b want 0 0 0 4 0",
                     clkout, tick, cnt, div_cur, pend);
        end
        rst = 0;
    endtask

    task automatic test_div4();
        bit exp_clk[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        en = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            total++;
            if (clkout !== exp_clk[i % 4] || tick !== (i % 4 == 0) || cnt !== 16'(i % 4) || div_cur !== 16'd4) begin
                bad++;
                $display("FAIL div4 cyc%0d: got clk=%0b tick=%0b cnt=%0d div=%0d want clk=%0b tick=%0b cnt=%0d div=4",
                         i, clkout, tick, cnt, div_cur, exp_clk[i % 4], (i % 4 == 0), i % 4);
            end
        end
    endtask

    task automatic test_load5();
        int k = 0;
        while (cnt !== 16'd1 && k < 20) begin step(); k++; end
        total++;
        if (cnt !== 16'd1) begin bad++; $display("FAIL load5_wait: cnt=%0d want 1", cnt); end
        div = 16'd5; div_ld = 1;
        step();
        div_ld = 0;
        total++;
        if (pend !== 1'b1 || div_cur !== 16'd4) begin
            bad++; $display("FAIL load5_pend: pend=%0b div=%0d want 1 4", pend, div_cur);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if ({clkout, tick, cnt, div_cur, pend} !== {m_clk, m_tick, 16'(m_cnt), 16'(m_d), m_pend}) begin
                bad++;
                $display("FAIL load5 cyc%0d: got %0b %0b %0d %0d %0b want %0b %0b %0d %0d %0b", i,
                         clkout, tick, cnt, div_cur, pend, m_clk, m_tick, m_cnt, m_d, m_pend);
            end
        end
        total++;
        if (div_cur !== 16'd5) begin bad++; $display("FAIL load5_div: div=%0d want 5", div_cur); end
    endtask

    task automatic test_clamp();
        div = 16'd1; div_ld = 1; step();
        div = 16'd0; step();
        div_ld = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if ({clkout, tick, cnt, div_cur, pend} !== {m_clk, m_tick, 16'(m_cnt), 16'(m_d), m_pend}) begin
                bad++;
                $display("FAIL clamp cyc%0d: got %0b %0b %0d %0d %0b want %0b %0b %0d %0d %0b", i,
                         clkout, tick, cnt, div_cur, pend, m_clk, m_tick, m_cnt, m_d, m_pend);
            end
        end
        total++;
        if (div_cur !== 16'd2) begin bad++; $display("FAIL clamp_div: div=%0d want 2", div_cur); end
    endtask

    task automatic test_freeze();
        int k = 0;
        rst = 1; step(); rst = 0; en = 1;
        while (cnt !== 16'd2 && k < 20) begin step(); k++; end
        en = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            total++;
            if (cnt !== 16'd2 || clkout !== 1'b1 || tick !== 1'b0) begin
                bad++;
                $display("FAIL freeze cyc%0d: cnt=%0d clk=%0b tick=%0b want 2 1 0", i, cnt, clkout, tick);
            end
        end
        en = 1; step();
        total++;
        if (cnt !== 16'd3) begin bad++; $display("FAIL freeze_resume: cnt=%0d want 3", cnt); end
    endtask

    task automatic test_reset_pending();
        int k = 0;
        while (cnt !== 16'd1 && k < 20) begin step(); k++; end
        div = 16'd9; div_ld = 1; step(); div_ld = 0;
        step();
        total++;
        if (cnt !== 16'd3 || pend !== 1'b1) begin
            bad++; $display("FAIL rstpend_setup: cnt=%0d pend=%0b want 3 1", cnt, pend);
        end
        rst = 1; step(); rst = 0;
        total++;
        if ({clkout, tick, cnt, div_cur, pend} !== {1'b0, 1'b0, 16'd0, 16'd4, 1'b0}) begin
            bad++;
            $display("FAIL rstpend: got %0b %0b %0d %0d %0b want 0 0 0 4 0", clkout, tick, cnt, div_cur, pend);
        end
        // A fresh period after reset must still run with the reset divisor.
        for (int i = 0; i < 8; i++) step();
        total++;
        if (div_cur !== 16'd4) begin bad++; $display("FAIL rstpend_after: div=%0d want 4", div_cur); end
    endtask

    task automatic test_wrap_load();
        int k = 0;
        while (cnt !== 16'd3 && k < 20) begin step(); k++; end
        div = 16'hFFFF; div_ld = 1; step(); div_ld = 0;
        total++;
        if (div_cur !== 16'hFFFF || pend !== 1'b0 || cnt !== 16'd0 || tick !== 1'b1) begin
            bad++;
            $display("FAIL wrapload: div=%0d pend=%0b cnt=%0d tick=%0b want 65535 0 0 1", div_cur, pend, cnt, tick);
        end
        for (int i = 0; i < 6; i++) step();
        total++;
        if (cnt !== 16'd6 || clkout !== 1'b0) begin
            bad++; $display("FAIL wrapload_run: cnt=%0d clk=%0b want 6 0", cnt, clkout);
        end
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_sync();
        if (HAS_SYNC) begin
            int k = 0;
            en = 1;
            while (cnt !== 16'd2 && k < 20) begin step(); k++; end
            sync = 1; step(); sync = 0;
            total++;
            if (cnt !== 16'd0 || clkout !== 1'b0 || tick !== 1'b0) begin
                bad++; $display("FAIL sync: cnt=%0d clk=%0b tick=%0b want 0 0 0", cnt, clkout, tick);
            end
            for (int i = 1; i <= 4; i++) begin
                step();
                total++;
                if (tick !== (i == 4)) begin
                    bad++; $display("FAIL sync_tick cyc%0d: tick=%0b want %0b", i, tick, (i == 4));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            en     = ($urandom_range(0, 9) != 0);
            div_ld = ($urandom_range(0, 14) == 0);
            div    = 16'($urandom_range(0, 9));
            sync   = HAS_SYNC && ($urandom_range(0, 59) == 0);
            step();
            total++;
            if ({clkout, tick, cnt, div_cur, pend} !== {m_clk, m_tick, 16'(m_cnt), 16'(m_d), m_pend}) begin
                bad++;
                $display("FAIL random cyc%0d: got %0b %0b %0d %0d %0b want %0b %0b %0d %0d %0b", i,
                         clkout, tick, cnt, div_cur, pend, m_clk, m_tick, m_cnt, m_d, m_pend);
            end
        end
        rst = 0; div_ld = 0; sync = 0;
    endtask

    initial begin
        m_cnt = 0; m_d = 4; m_pend = 0; m_pending = 4; m_tick = 0; m_clk = 0;
        test_reset();
        test_div4();
        test_load5();
        test_clamp();
        test_freeze();
        test_reset_pending();
        test_wrap_load();
        test_sync();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
